// File: rtl/cam_cfg_seq.sv
// Camera configuration sequencer: walks cfg_rom, forwards {addr,data} words to the SCCB master.
// Optional handshake watchdog enabled by defining CFG_TIMEOUT_EN.
//   state  | meaning
//   IDLE   | waiting for i_start after reset
//   FETCH  | ROM read latency cycle
//   DECODE | classify ROM word: write, delay marker, end marker
//   SEND   | write request held until i_sccb_ready
//   DELAY  | local dwell for the delay marker
//   NEXT   | advance address or stop at end of ROM space
//   FLUSH  | wait for the SCCB master to finish the last write
//   DONE   | sequence complete, waiting for restart
module cam_cfg_seq #(
    parameter int CLK_FREQ       = 25_000_000,
    parameter int DELAY_US       = 1000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic [7:0]  o_rom_addr,
    input  logic [15:0] i_rom_data,
    output logic        o_sccb_valid,
    input  logic        i_sccb_ready,
    output logic [7:0]  o_sccb_addr,
    output logic [7:0]  o_sccb_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam int          DELAY_CYC  = CLK_FREQ / 1_000_000 * DELAY_US;
    localparam logic [31:0] DELAY_LOAD = 32'(DELAY_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, SEND, DELAY, NEXT, FLUSH, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [7:0]  saddr_q, saddr_d;
    logic [7:0]  sdata_q, sdata_d;
    logic        done_q, done_d;
    logic [31:0] cnt_q, cnt_d;

`ifdef CFG_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            wd_fire;

    assign wd_fire = (wd_q == WD_LAST);
    assign o_err   = err_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`else
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            saddr_q <= '0;
            sdata_q <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            saddr_q <= saddr_d;
            sdata_q <= sdata_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        saddr_d = saddr_q;
        sdata_d = sdata_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
`ifdef CFG_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    addr_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (i_rom_data == 16'hFFFF) begin
                    state_d = FLUSH;
                end else if (i_rom_data == 16'hFFF0) begin
                    cnt_d   = DELAY_LOAD;
                    state_d = DELAY;
                end else begin
                    saddr_d = i_rom_data[15:8];
                    sdata_d = i_rom_data[7:0];
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (i_sccb_ready) begin
                    valid_d = 1'b0;
                    state_d = NEXT;
                end
`ifdef CFG_TIMEOUT_EN
                else if (wd_fire) begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            DELAY: begin
                if (cnt_q == '0) state_d = NEXT;
                else             cnt_d   = cnt_q - 32'd1;
            end
            NEXT: begin
                // Address space ends at 8'hFF; never wrap back to word 0.
                if (addr_q == 8'hFF) begin
                    state_d = FLUSH;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    state_d = FETCH;
                end
            end
            FLUSH: begin
                if (i_sccb_ready) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
`ifdef CFG_TIMEOUT_EN
                else if (wd_fire) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (i_start) begin
                    done_d  = 1'b0;
`ifdef CFG_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    addr_d  = '0;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef CFG_TIMEOUT_EN
        // Watchdog restarts whenever SEND or FLUSH is (re)entered.
        if ((state_d == state_q) && ((state_q == SEND) || (state_q == FLUSH)))
            wd_d = wd_q + 1'b1;
        else
            wd_d = '0;
`endif
    end

    assign o_rom_addr   = addr_q;
    assign o_sccb_valid = valid_q;
    assign o_sccb_addr  = saddr_q;
    assign o_sccb_data  = sdata_q;
    assign o_done       = done_q;
    assign o_busy       = (state_q != IDLE) && (state_q != DONE);

endmodule
